ps2_host_ctrl: RTL and testbench
================================

# ps2_host_ctrl

Host-to-device command sequencer for the PS/2 keyboard port. It takes one command byte from the CPU side, inhibits the bus, and clocks the byte out to the keyboard with odd parity. It then checks the line-level acknowledge and receives the keyboard's response byte (0xFA ACK / 0xFE resend). While it owns the bus it asserts `rx_inhibit`, so the scancode receiver/FIFO never enqueues the command echo or the response byte.

## Interface
- `INHIBIT_CYC`, 10000: clk cycles `ps2_clk` is held low before the request-to-send (at least 100 µs at system clock).
- `TIMEOUT_CYC`, 200000: maximum clk cycles between consecutive PS/2 clock falling edges once the bus is released.
- `RETRIES`, 2: resend attempts after a 0xFE response. Used only with `PS2_RESEND_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command byte offered.
- `cmd_data`  in  8  command byte.
- `cmd_ready`  out  1  controller idle; a command is accepted when `cmd_valid & cmd_ready`.
- `ps2_clk_in`, `ps2_data_in`  in  1 each  raw pad levels (asynchronous).
- `ps2_clk_oe`, `ps2_data_oe`  out  1 each  1 = drive pad low; 0 = release (open-drain).
- `rx_inhibit`  out  1  scancode receiver must discard bus activity while high.
- `done`  out  1  one-cycle pulse: response 0xFA received.
- `err`  out  1  one-cycle pulse: transaction failed.
- `err_code`  out  2  0 timeout, 1 no line ack, 2 bad response frame, 3 non-ACK response. Valid with `err`, held until the next `err`.
- `resp`  out  8  last response byte received. Held.

## Operation
- Inputs pass through a 2-flop synchronizer. A falling edge is sync_clk 1→0 between consecutive cycles.
- States and transitions:
  - IDLE → INHIBIT on accept; latch the byte and compute the frame.
  - INHIBIT: `clk_oe=1` for INHIBIT_CYC cycles → REQ.
  - REQ: `clk_oe=1`, `data_oe=1` for 1 cycle → SEND.
  - SEND: `clk_oe=0`, start bit driven (`data_oe=1`). On falling edges 1..8, present d0..d7 (LSB first). Edge 9 presents parity = `~^cmd`. Edge 10 releases data (stop bit). Bit value b drives `data_oe=~b`. Edge 10 → LACK.
  - LACK: next falling edge samples data; 0 → RXWAIT, 1 → fail code 1.
  - RXWAIT/RX: sample data on each of 11 falling edges (start, d0..d7, parity, stop). Then CHECK.
  - CHECK:
    - Start≠0, stop≠1 or even parity → fail code 2.
    - Byte 0xFA → `done`.
    - Byte 0xFE → resend (see Configuration).
    - Any other byte → fail code 3.
    - `resp` is updated in CHECK regardless of outcome.
- Timeout counter clears on every falling edge and on entry to SEND. It runs in SEND/LACK/RXWAIT/RX. Reaching TIMEOUT_CYC → fail code 0.
- Fail or done: release both pads, pulse `err` or `done`, return to IDLE. `done` and `err` are never both high.
- `cmd_valid` while not idle is ignored. No queueing.
- PS/2 edges during IDLE, INHIBIT and REQ are ignored. Inhibiting aborts any keyboard transmission in progress; the keyboard retransmits later.

## Timing
- Reset: all outputs 0, state IDLE, retry count 0, `resp`=0, `err_code`=0. `cmd_ready` rises on the first cycle after `rst_n` goes high.
- Reset mid-operation: pads released and `rx_inhibit`=0 on the clock edge sampling `rst_n`=0. No `done`/`err` pulse.
- Accept on cycle T: `cmd_ready`=0, `rx_inhibit`=1, `clk_oe`=1 from T+1.
- `clk_oe` is high for exactly INHIBIT_CYC+1 cycles (INHIBIT plus REQ).
- Pad outputs change at most once per clk cycle, the cycle after the synchronized edge is seen (2–3 cycles after the pad edge).
- `done`/`err` pulse in the cycle after CHECK or fail. In that same cycle, `rx_inhibit`=0 and `cmd_ready`=1.
- Timeout counter width: `$clog2(TIMEOUT_CYC+1)`. Counter saturates, never wraps.

## Configuration
- `PS2_RESEND_EN` defined: 0xFE response with retry count < RETRIES → increment the count, return to INHIBIT with the same byte, keep `rx_inhibit` high, no pulse. Exhausted → fail code 3. Retry count clears on every accept.
- Undefined: 0xFE → fail code 3 immediately. RETRIES unused, no retry counter synthesized.

## Test plan
- Send 0xED; device model line-acks and returns 0xFA → bits sent 1,0,1,1,0,1,1,1 then parity 1, stop released; `done` pulse, `resp`=0xFA, `rx_inhibit` low after.
- Send 0xFF; device never clocks → `err` with `err_code`=0, exactly TIMEOUT_CYC cycles after SEND entry; pads released.
- Send 0x55; device leaves data high on edge 11 → `err`, `err_code`=1, no response received.
- Send 0xF4; device returns 0xFE then 0xFA → with `PS2_RESEND_EN`: two full transmissions, single `done`, `resp`=0xFA; without it: `err`, `err_code`=3, `resp`=0xFE.
- Device returns 0xFA with parity bit 0 → `err`, `err_code`=2; separately, returns 0xAA → `err_code`=3.
- Assert `rst_n`=0 during SEND bit 4 → next cycle `clk_oe`=`data_oe`=`rx_inhibit`=0. A new command accepted after release completes normally.

Source files
------------

// File: rtl/ps2_host_ctrl.sv
// PS/2 host-to-device command sequencer: inhibit, send byte with odd parity, check line ack, receive response.
// Optional feature: define PS2_RESEND_EN to retry the command up to RETRIES times on a 0xFE response.
module ps2_host_ctrl #(
    parameter int unsigned INHIBIT_CYC = 10000,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter int unsigned RETRIES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       rx_inhibit_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic [7:0] resp_o
);

    localparam int unsigned IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC + 1) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FW = 11;

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_NO_ACK  = 2'd1;
    localparam logic [1:0] ERR_FRAME   = 2'd2;
    localparam logic [1:0] ERR_NAK     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_LACK,
        S_RXWAIT,
        S_RX,
        S_CHECK
    } state_e;

    state_e          state_q, state_d;
    logic            clk_s1_q, clk_s2_q, clk_prev_q;
    logic            dat_s1_q, dat_s2_q;
    logic [FW-1:0]   tx_frame_q, tx_frame_d;
    logic [FW-1:0]   rx_frame_q, rx_frame_d;
    logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            rx_inh_q, rx_inh_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [7:0]      resp_q, resp_d;

    logic            fall_c;
    logic            tmo_run_c;
    logic            tmo_hit_c;
    logic [7:0]      rx_byte_c;
    logic            frame_bad_c;

`ifdef PS2_RESEND_EN
    localparam int unsigned RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    logic [RW-1:0]   retry_q, retry_d;
`else
    logic            unused_retries;
    assign unused_retries = ^RETRIES;
`endif

    assign fall_c      = clk_prev_q & ~clk_s2_q;
    assign tmo_run_c   = (state_q == S_SEND) || (state_q == S_LACK) ||
                         (state_q == S_RXWAIT) || (state_q == S_RX);
    assign tmo_hit_c   = tmo_run_c && !fall_c && (tmo_cnt_q >= TW'(TIMEOUT_CYC - 1));
    assign rx_byte_c   = rx_frame_q[8:1];
    // Valid frame: start 0, stop 1, odd parity over data plus parity bit.
    assign frame_bad_c = rx_frame_q[0] | ~rx_frame_q[10] | ~(^rx_frame_q[9:1]);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        tx_frame_d = tx_frame_q;
        rx_frame_d = rx_frame_q;
        inh_cnt_d  = inh_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        resp_d     = resp_q;
        cmd_ready_d = 1'b0;
        clk_oe_d    = 1'b0;
        data_oe_d   = 1'b0;
        rx_inh_d    = 1'b0;
`ifdef PS2_RESEND_EN
        retry_d    = retry_q;
`endif

        if (tmo_run_c) begin
            if (fall_c) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q != TW'(TIMEOUT_CYC)) begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end

        if (tmo_hit_c) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        tx_frame_d = {1'b1, ~^cmd_data_i, cmd_data_i, 1'b0};
                        inh_cnt_d  = '0;
                        state_d    = S_INHIBIT;
`ifdef PS2_RESEND_EN
                        retry_d    = '0;
`endif
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt_q == IW'(INHIBIT_CYC - 1)) begin
                        state_d = S_REQ;
                    end else begin
                        inh_cnt_d = inh_cnt_q + IW'(1);
                    end
                end
                S_REQ: begin
                    state_d   = S_SEND;
                    tmo_cnt_d = '0;
                    bit_cnt_d = '0;
                end
                S_SEND: begin
                    // Falling edge k presents frame bit k; edge 10 releases data for the stop bit.
                    if (fall_c) begin
                        if (bit_cnt_q == 4'd9) begin
                            state_d = S_LACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_LACK: begin
                    if (fall_c) begin
                        if (!dat_s2_q) begin
                            state_d   = S_RXWAIT;
                            bit_cnt_d = '0;
                        end else begin
                            state_d    = S_IDLE;
                            err_d      = 1'b1;
                            err_code_d = ERR_NO_ACK;
                        end
                    end
                end
                S_RXWAIT: begin
                    if (fall_c) begin
                        rx_frame_d[0] = dat_s2_q;
                        bit_cnt_d     = 4'd1;
                        state_d       = S_RX;
                    end
                end
                S_RX: begin
                    if (fall_c) begin
                        rx_frame_d[bit_cnt_q] = dat_s2_q;
                        if (bit_cnt_q == 4'd10) begin
                            state_d = S_CHECK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_CHECK: begin
                    resp_d  = rx_byte_c;
                    state_d = S_IDLE;
                    if (frame_bad_c) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_FRAME;
                    end else if (rx_byte_c == 8'hFA) begin
                        done_d = 1'b1;
`ifdef PS2_RESEND_EN
                    end else if ((rx_byte_c == 8'hFE) && (retry_q < RW'(RETRIES))) begin
                        retry_d   = retry_q + RW'(1);
                        inh_cnt_d = '0;
                        state_d   = S_INHIBIT;
`endif
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NAK;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Pad and handshake outputs follow the state being entered.
        cmd_ready_d = (state_d == S_IDLE);
        rx_inh_d    = (state_d != S_IDLE);
        clk_oe_d    = (state_d == S_INHIBIT) || (state_d == S_REQ);
        data_oe_d   = (state_d == S_REQ) ||
                      ((state_d == S_SEND) && !tx_frame_d[bit_cnt_d]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            tx_frame_q  <= '0;
            rx_frame_q  <= '0;
            inh_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            cmd_ready_q <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            rx_inh_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            resp_q      <= '0;
`ifdef PS2_RESEND_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            clk_s1_q    <= ps2_clk_i;
            clk_s2_q    <= clk_s1_q;
            clk_prev_q  <= clk_s2_q;
            dat_s1_q    <= ps2_data_i;
            dat_s2_q    <= dat_s1_q;
            tx_frame_q  <= tx_frame_d;
            rx_frame_q  <= rx_frame_d;
            inh_cnt_q   <= inh_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            rx_inh_q    <= rx_inh_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            resp_q      <= resp_d;
`ifdef PS2_RESEND_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;
    assign rx_inhibit_o  = rx_inh_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign err_code_o    = err_code_q;
    assign resp_o        = resp_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Scoreboard bench for ps2_host_ctrl with a behavioural open-drain PS/2 keyboard model.
module tb_ps2_host_ctrl;

    localparam int unsigned INH = 20;
    localparam int unsigned TMO = 500;
    localparam int          HI  = 8;
    localparam int          LO  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       cmd_ready, clk_oe, data_oe, rx_inhibit, done, err;
    logic [1:0] err_code;
    logic [7:0] resp;
    logic       pad_clk, pad_data;

    always #5 clk = ~clk;

    // Open-drain bus: either side may pull low.
    assign pad_clk  = dev_clk  & ~clk_oe;
    assign pad_data = dev_data & ~data_oe;

    ps2_host_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .RETRIES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_data_i    (cmd_data),
        .cmd_ready_o   (cmd_ready),
        .ps2_clk_i     (pad_clk),
        .ps2_data_i    (pad_data),
        .ps2_clk_oe_o  (clk_oe),
        .ps2_data_oe_o (data_oe),
        .rx_inhibit_o  (rx_inhibit),
        .done_o        (done),
        .err_o         (err),
        .err_code_o    (err_code),
        .resp_o        (resp)
    );

    typedef struct {
        bit is_done;
        int code;
        int resp;
        int lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic par);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Monitor: pops one expectation per done/err pulse.
    initial begin : monitor
        exp_t e;
        int   since_send;
        logic oe_prev;
        since_send = 0;
        oe_prev    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!clk_oe && oe_prev) since_send = 0;
            else since_send++;
            oe_prev = clk_oe;
            if (done || err) begin
                chk("done_err_exclusive", int'(done & err), 0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none at %0t", done, err, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_kind_done", int'(done), int'(e.is_done));
                    if (!e.is_done) chk("err_code", int'(err_code), e.code);
                    chk("resp", int'(resp), e.resp);
                    if (e.lat >= 0) chk("timeout_latency", since_send, e.lat);
                    chk("rx_inhibit_after", int'(rx_inhibit), 0);
                    chk("cmd_ready_after", int'(cmd_ready), 1);
                    chk("pads_released", int'({clk_oe, data_oe}), 0);
                end
            end
        end
    end

    task automatic send_cmd(input logic [7:0] b, input bit push, input exp_t e);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_before_accept", int'(cmd_ready), 1);
        if (push) sbq.push_back(e);
        cmd_valid = 1'b1;
        cmd_data  = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("accept_cmd_ready_low", int'(cmd_ready), 0);
        chk("accept_rx_inhibit", int'(rx_inhibit), 1);
        chk("accept_clk_oe", int'(clk_oe), 1);
    endtask

    // Keyboard side of a host-to-device frame; nedges < 10 stops part-way through.
    task automatic dev_receive(input logic [7:0] exp_b, input logic ack, input int nedges);
        int           w;
        logic [10:1]  bits;
        w    = 0;
        bits = '0;
        while (!(!clk_oe && data_oe && rx_inhibit) && w < int'(INH) + 100) begin
            cyc(1);
            w++;
        end
        checks++;
        if (w >= int'(INH) + 100) begin
            errors++;
            $display("FAIL send_entry_wait: got no request-to-send expected one within %0d cycles", INH + 100);
            return;
        end
        cyc(4);
        for (int k = 1; k <= nedges; k++) begin
            dev_clk = 1'b0;
            cyc(LO);
            dev_clk = 1'b1;
            cyc(2);
            bits[k] = pad_data;
            cyc(HI - 2);
        end
        if (nedges < 10) return;
        chk("tx_byte", int'(bits[8:1]), int'(exp_b));
        chk("tx_parity", int'(bits[9]), int'(~^exp_b));
        chk("tx_stop", int'(bits[10]), 1);
        dev_data = ack;
        cyc(HI);
        dev_clk = 1'b0;
        cyc(LO);
        dev_clk = 1'b1;
        cyc(HI);
        dev_data = 1'b1;
        cyc(HI);
    endtask

    task automatic dev_send(input logic [10:0] f);
        for (int i = 0; i < 11; i++) begin
            dev_data = f[i];
            cyc(HI);
            dev_clk = 1'b0;
            cyc(LO);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
        cyc(HI);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 20000) begin
            cyc(1);
            w++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL pulse_wait: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
        cyc(20);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        exp_t none;
        none = '{1'b0, 0, 0, -1};

        cyc(3);
        chk("reset_cmd_ready", int'(cmd_ready), 0);
        chk("reset_pads", int'({clk_oe, data_oe}), 0);
        chk("reset_rx_inhibit", int'(rx_inhibit), 0);
        chk("reset_pulses", int'({done, err}), 0);
        chk("reset_resp", int'(resp), 0);
        chk("reset_err_code", int'(err_code), 0);
        rst_n = 1'b1;
        cyc(1);
        chk("cmd_ready_after_reset", int'(cmd_ready), 1);

        // 0xED: full good transaction.
        send_cmd(8'hED, 1'b1, '{1'b1, 0, 8'hFA, -1});
        dev_receive(8'hED, 1'b0, 10);
        dev_send(frame(8'hFA, 1'b1));
        wait_idle();

        // 0xFF: keyboard never clocks.
        send_cmd(8'hFF, 1'b1, '{1'b0, 0, 8'hFA, int'(TMO)});
        wait_idle();

        // 0x55: no line acknowledge.
        send_cmd(8'h55, 1'b1, '{1'b0, 1, 8'hFA, -1});
        dev_receive(8'h55, 1'b1, 10);
        wait_idle();

        // 0xF4: resend request followed by ACK.
`ifdef PS2_RESEND_EN
        send_cmd(8'hF4, 1'b1, '{1'b1, 0, 8'hFA, -1});
        dev_receive(8'hF4, 1'b0, 10);
        dev_send(frame(8'hFE, 1'b0));
        dev_receive(8'hF4, 1'b0, 10);
        dev_send(frame(8'hFA, 1'b1));
`else
        send_cmd(8'hF4, 1'b1, '{1'b0, 3, 8'hFE, -1});
        dev_receive(8'hF4, 1'b0, 10);
        dev_send(frame(8'hFE, 1'b0));
`endif
        wait_idle();

        // 0xFA with wrong parity.
        send_cmd(8'hF3, 1'b1, '{1'b0, 2, 8'hFA, -1});
        dev_receive(8'hF3, 1'b0, 10);
        dev_send(frame(8'hFA, 1'b0));
        wait_idle();

        // 0xAA is a well-formed but non-ACK response.
        send_cmd(8'hF2, 1'b1, '{1'b0, 3, 8'hAA, -1});
        dev_receive(8'hF2, 1'b0, 10);
        dev_send(frame(8'hAA, 1'b1));
        wait_idle();

        // Reset while the host is presenting d3 (0) of 0x12.
        send_cmd(8'h12, 1'b0, none);
        dev_receive(8'h12, 1'b0, 4);
        chk("pre_reset_data_oe", int'(data_oe), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_clk_oe", int'(clk_oe), 0);
        chk("midreset_data_oe", int'(data_oe), 0);
        chk("midreset_rx_inhibit", int'(rx_inhibit), 0);
        cyc(2);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        rst_n    = 1'b1;
        cyc(1);
        chk("post_reset_resp", int'(resp), 0);
        chk("post_reset_err_code", int'(err_code), 0);
        send_cmd(8'hED, 1'b1, '{1'b1, 0, 8'hFA, -1});
        dev_receive(8'hED, 1'b0, 10);
        dev_send(frame(8'hFA, 1'b1));
        wait_idle();

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
